priority_decoder_accum: RTL and testbench

Inverse end of the serial priority-encode path: accepts a stream of bit indices (highest set bit first, one per beat) and rebuilds the original WIDTH-bit word. Each accepted index is decoded to one-hot and OR-accumulated. The rebuilt word, a set-bit count and an error flag are presented on a valid/ready output when the beat marked last is accepted. It sits downstream of the encoder datapath and restores vectors for the consumer logic.

---
 rtl/priority_decoder_accum_if.sv | 28 ++
 rtl/priority_decoder_accum.sv | 133 +++++++++++++
 tb/tb_priority_decoder_accum.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/priority_decoder_accum_if.sv
// Beat-in / word-out handshake bundle for priority_decoder_accum.
// master = upstream/consumer side (testbench), slave = the decoder block.
interface priority_decoder_accum_if #(
  parameter int WIDTH = 8
);
  localparam int IDX_W = $clog2(WIDTH);

  logic             in_valid;
  logic             in_ready;
  logic [IDX_W-1:0] in_idx;
  logic             in_zero;
  logic             in_last;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic [IDX_W:0]   out_count;
  logic             out_err;

  modport master (
    output in_valid, in_idx, in_zero, in_last, out_ready,
    input  in_ready, out_valid, out_data, out_count, out_err
  );

  modport slave (
    input  in_valid, in_idx, in_zero, in_last, out_ready,
    output in_ready, out_valid, out_data, out_count, out_err
  );
endinterface

// File: rtl/priority_decoder_accum.sv
// Rebuilds a WIDTH-bit word from a stream of set-bit indices (highest first).
// Optional ordering/duplicate checking is enabled by defining ORDER_CHECK_EN.
module priority_decoder_accum #(
  parameter int WIDTH = 8
) (
  input logic                    clk,
  input logic                    rst,
  priority_decoder_accum_if.slave bus
);
  localparam int IDX_W = $clog2(WIDTH);
  localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);
  localparam logic [IDX_W:0]   CNT_MAX = (IDX_W+1)'(WIDTH);
  localparam logic [IDX_W:0]   CNT_ONE = (IDX_W+1)'(1);

  typedef enum logic {ACCUM, HOLD} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d, acc_nx;
  logic [IDX_W:0]   cnt_q, cnt_d, cnt_nx;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic [IDX_W:0]   out_count_q, out_count_d;
  logic             accept;

  assign bus.in_ready  = (state_q == ACCUM);
  assign bus.out_valid = (state_q == HOLD);
  assign bus.out_data  = out_data_q;
  assign bus.out_count = out_count_q;
  assign accept        = bus.in_valid && (state_q == ACCUM);

  always_comb begin
    // NOTE: every signal written here gets a default first, so no latch is inferred.
    state_d     = state_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    out_data_d  = out_data_q;
    out_count_d = out_count_q;
    acc_nx      = acc_q;
    cnt_nx      = cnt_q;
    if (!bus.in_zero) begin
      acc_nx = acc_q | (ONE << bus.in_idx);
      cnt_nx = (cnt_q == CNT_MAX) ? CNT_MAX : cnt_q + CNT_ONE;
    end
    case (state_q)
      ACCUM: begin
        if (accept) begin
          if (bus.in_last) begin
            out_data_d  = acc_nx;
            out_count_d = cnt_nx;
            acc_d       = '0;
            cnt_d       = '0;
            state_d     = HOLD;
          end else begin
            acc_d = acc_nx;
            cnt_d = cnt_nx;
          end
        end
      end
      HOLD: begin
        if (bus.out_ready) state_d = ACCUM;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ACCUM;
      acc_q       <= '0;
      cnt_q       <= '0;
      out_data_q  <= '0;
      out_count_q <= '0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      out_data_q  <= out_data_d;
      out_count_q <= out_count_d;
    end
  end

`ifdef ORDER_CHECK_EN
  logic [IDX_W-1:0] prev_q, prev_d;
  logic             has_idx_q, has_idx_d;
  logic             err_q, err_d, err_nx;
  logic             out_err_q, out_err_d;

  // Indices must strictly descend; empty beats are legal only as a lone last beat.
  always_comb begin
    err_nx = err_q;
    if (bus.in_zero) begin
      if (!bus.in_last || has_idx_q) err_nx = 1'b1;
    end else if (has_idx_q && (bus.in_idx >= prev_q)) begin
      err_nx = 1'b1;
    end
    prev_d    = prev_q;
    has_idx_d = has_idx_q;
    err_d     = err_q;
    out_err_d = out_err_q;
    if (accept) begin
      if (bus.in_last) begin
        prev_d    = '0;
        has_idx_d = 1'b0;
        err_d     = 1'b0;
        out_err_d = err_nx;
      end else begin
        err_d = err_nx;
        if (!bus.in_zero) begin
          prev_d    = bus.in_idx;
          has_idx_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_q    <= '0;
      has_idx_q <= 1'b0;
      err_q     <= 1'b0;
      out_err_q <= 1'b0;
    end else begin
      prev_q    <= prev_d;
      has_idx_q <= has_idx_d;
      err_q     <= err_d;
      out_err_q <= out_err_d;
    end
  end

  assign bus.out_err = out_err_q;
`else
  assign bus.out_err = 1'b0;
`endif
endmodule

// File: tb/tb_priority_decoder_accum.sv
// Self-checking bench for priority_decoder_accum: directed words from the
// test plan plus randomized words checked against a word-level reference model.
module tb_priority_decoder_accum;
  localparam int W  = 8;
  localparam int IW = $clog2(W);
  localparam int MAXB = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;

  priority_decoder_accum_if #(.WIDTH(W)) bus ();

  priority_decoder_accum #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  int unsigned b_idx  [MAXB];
  bit          b_zero [MAXB];

  // Word-level model: OR of one-hots, saturating count of index beats,
  // and an error if the index sequence is not strictly decreasing or an
  // empty beat appears anywhere except as the sole beat of a word.
  function automatic void model(input int n, output logic [W-1:0] d,
                                output logic [IW:0] c, output logic e);
    int unsigned idxs[$];
    int nz;
    d  = '0;
    nz = 0;
    e  = 1'b0;
    for (int i = 0; i < n; i++) begin
      if (!b_zero[i]) begin
        d[b_idx[i]] = 1'b1;
        idxs.push_back(b_idx[i]);
        nz++;
      end
    end
    c = (nz > W) ? (IW+1)'(W) : (IW+1)'(nz);
`ifdef ORDER_CHECK_EN
    for (int i = 1; i < idxs.size(); i++)
      if (idxs[i] >= idxs[i-1]) e = 1'b1;
    for (int i = 0; i < n; i++)
      if (b_zero[i] && !(n == 1)) e = 1'b1;
`endif
  endfunction

  // Sends b_idx/b_zero[0..n-1] (last on n-1), then checks the emitted word,
  // holds out_ready low for hold cycles, and checks the release handshake.
  task automatic run_word(input string name, input int n, input int hold, input bit bubbles);
    logic [W-1:0] ed;
    logic [IW:0]  ec;
    logic         ee;
    int i, guard;
    bit v;
    model(n, ed, ec, ee);
    bus.out_ready = (hold == 0);
    i = 0;
    guard = 0;
    while (i < n && guard < 400) begin
      @(negedge clk);
      v = bubbles ? 1'($urandom_range(0, 1)) : 1'b1;
      bus.in_valid = v;
      if (v) begin
        bus.in_idx  = IW'(b_idx[i]);
        bus.in_zero = b_zero[i];
        bus.in_last = (i == n - 1);
      end else begin
        bus.in_idx  = IW'($urandom_range(0, W - 1));
        bus.in_zero = 1'($urandom_range(0, 1));
        bus.in_last = 1'($urandom_range(0, 1));
      end
      if (v && bus.in_ready) i++;
      guard++;
    end
    checks++;
    if (i != n) begin
      failures++;
      $display("FAIL %s beat_timeout accepted=%0d required=%0d", name, i, n);
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    checks++;
    if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0) begin
      failures++;
      $display("FAIL %s latency out_valid=%b in_ready=%b required 1/0", name, bus.out_valid, bus.in_ready);
    end
    checks++;
    if (bus.out_data !== ed || bus.out_count !== ec || bus.out_err !== ee) begin
      failures++;
      $display("FAIL %s word data=%b count=%0d err=%b required data=%b count=%0d err=%b",
               name, bus.out_data, bus.out_count, bus.out_err, ed, ec, ee);
    end
    for (int k = 1; k < hold; k++) begin
      @(negedge clk);
      checks++;
      if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 || bus.out_data !== ed ||
          bus.out_count !== ec || bus.out_err !== ee) begin
        failures++;
        $display("FAIL %s hold_%0d valid=%b ready=%b data=%b required valid=1 ready=0 data=%b",
                 name, k, bus.out_valid, bus.in_ready, bus.out_data, ed);
      end
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.out_data !== ed || bus.out_count !== ec) begin
      failures++;
      $display("FAIL %s release valid=%b ready=%b data=%b count=%0d required valid=0 ready=1 data=%b count=%0d",
               name, bus.out_valid, bus.in_ready, bus.out_data, bus.out_count, ed, ec);
    end
  endtask

  task automatic check_zero_outputs(input string name);
    checks++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.out_data !== '0 ||
        bus.out_count !== '0 || bus.out_err !== 1'b0) begin
      failures++;
      $display("FAIL %s valid=%b ready=%b data=%b count=%0d err=%b required 0/1/0/0/0",
               name, bus.out_valid, bus.in_ready, bus.out_data, bus.out_count, bus.out_err);
    end
  endtask

  task automatic test_reset();
    bus.in_valid  = 1'b0;
    bus.in_idx    = '0;
    bus.in_zero   = 1'b0;
    bus.in_last   = 1'b0;
    bus.out_ready = 1'b1;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check_zero_outputs("reset_asserted");
    rst = 1'b0;
    @(negedge clk);
    check_zero_outputs("reset_released");
  endtask

  task automatic test_basic();
    int unsigned seq[5] = '{6, 3, 2, 1, 0};
    for (int i = 0; i < 5; i++) begin b_idx[i] = seq[i]; b_zero[i] = 1'b0; end
    run_word("basic_63210", 5, 0, 1'b0);
  endtask

  task automatic test_empty_word();
    b_idx[0] = 3; b_zero[0] = 1'b1;
    run_word("empty_word", 1, 0, 1'b0);
  endtask

  task automatic test_backpressure();
    int unsigned seq[5] = '{7, 6, 3, 2, 0};
    for (int i = 0; i < 5; i++) begin b_idx[i] = seq[i]; b_zero[i] = 1'b0; end
    run_word("backpressure", 5, 6, 1'b0);
  endtask

  task automatic test_order_dup();
    b_idx[0] = 2; b_zero[0] = 1'b0;
    b_idx[1] = 5; b_zero[1] = 1'b0;
    run_word("out_of_order", 2, 0, 1'b0);
    b_idx[0] = 4; b_idx[1] = 4;
    run_word("duplicate", 2, 0, 1'b0);
  endtask

  task automatic test_saturate();
    for (int i = 0; i < 10; i++) begin b_idx[i] = 0; b_zero[i] = 1'b0; end
    run_word("count_saturate", 10, 0, 1'b0);
  endtask

  task automatic test_reset_mid_word();
    @(negedge clk);
    bus.in_valid = 1'b1; bus.in_idx = IW'(5); bus.in_zero = 1'b0; bus.in_last = 1'b0;
    @(negedge clk);
    bus.in_idx = IW'(4);
    @(negedge clk);
    bus.in_valid = 1'b0;
    #1 rst = 1'b1;
    #1 check_zero_outputs("reset_mid_word");
    @(negedge clk);
    rst = 1'b0;
    b_idx[0] = 7; b_zero[0] = 1'b0;
    run_word("after_reset", 1, 0, 1'b0);
  endtask

  task automatic test_bubbles();
    int unsigned seq[3] = '{5, 4, 1};
    for (int i = 0; i < 3; i++) begin b_idx[i] = seq[i]; b_zero[i] = 1'b0; end
    run_word("bubbles_541", 3, 0, 1'b1);
  endtask

  task automatic test_random();
    int n;
    for (int w = 0; w < 40; w++) begin
      n = $urandom_range(1, 11);
      for (int i = 0; i < n; i++) begin
        b_idx[i]  = $urandom_range(0, W - 1);
        b_zero[i] = ($urandom_range(0, 7) == 0);
      end
      run_word($sformatf("random_%0d", w), n, $urandom_range(0, 3), 1'($urandom_range(0, 1)));
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_empty_word();
    test_backpressure();
    test_order_dup();
    test_saturate();
    test_reset_mid_word();
    test_bubbles();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
